data_mem_march_bist: RTL and testbench



---
 rtl/data_mem_bist_pkg.sv | 36 +++
 rtl/bist_addr_gen.sv | 41 ++++
 rtl/data_mem_march_bist.sv | 165 ++++++++++++++++
 tb/tb_data_mem_march_bist.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_bist_pkg.sv
// Shared definitions for the data memory March C- BIST: FSM state codes,
// per-element read/write encoding and run-length constant.
package data_mem_bist_pkg;

    localparam int unsigned CYCLES_PER_WORD = 11;

    typedef logic [2:0] state_t;

    localparam state_t StIdle    = 3'd0;
    localparam state_t StWOnly   = 3'd1;
    localparam state_t StRd      = 3'd2;
    localparam state_t StWrChk   = 3'd3;
    localparam state_t StRdLast  = 3'd4;
    localparam state_t StChkLast = 3'd5;
    localparam state_t StDone    = 3'd6;

    // rd_inv/wr_inv select D1 (~background) instead of D0 for that operation
    typedef struct packed {
        logic down;
        logic rd_inv;
        logic wr_inv;
    } elem_t;

    function automatic elem_t elem_info(input logic [2:0] idx);
        elem_t e;
        case (idx)
            3'd1:    e = '{down: 1'b0, rd_inv: 1'b0, wr_inv: 1'b1};
            3'd2:    e = '{down: 1'b0, rd_inv: 1'b1, wr_inv: 1'b0};
            3'd3:    e = '{down: 1'b1, rd_inv: 1'b0, wr_inv: 1'b1};
            3'd4:    e = '{down: 1'b1, rd_inv: 1'b1, wr_inv: 1'b0};
            default: e = '{down: 1'b0, rd_inv: 1'b0, wr_inv: 1'b0};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/bist_addr_gen.sv
// Up/down word-address counter for the March BIST, with load-to-start and an
// end-of-range flag for the current direction.
module bist_addr_gen #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DEPTH  = 8000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              load_down,
    input  logic              step,
    input  logic              down,
    output logic [ADDR_W-1:0] addr,
    output logic              at_end
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        addr_d = addr_q;
        if (load) begin
            addr_d = load_down ? LastAddr : '0;
        end else if (step) begin
            addr_d = down ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr   = addr_q;
    assign at_end = down ? (addr_q == '0) : (addr_q == LastAddr);

endmodule

// File: rtl/data_mem_march_bist.sv
// March C- BIST master for the single-port data memory: drives the Avalon-MM
// slave port, checks read data and records pass/fail, first failure and count.
module data_mem_march_bist
    import data_mem_bist_pkg::*;
#(
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 8000,
    parameter int unsigned ERR_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_W-1:0]     bg_pattern,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_W-1:0]     fail_addr,
    output logic [DATA_W-1:0]     fail_data,
    output logic [DATA_W-1:0]     fail_expected,
    output logic [ERR_CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata
);

    state_t             state_q, state_d;
    logic [2:0]         elem_q, elem_d;
    logic [DATA_W-1:0]  bg_q;
    logic               fail_q;
    logic [ERR_CNT_W-1:0] err_q;
    logic [ADDR_W-1:0]  fail_addr_q;
    logic [DATA_W-1:0]  fail_data_q, fail_exp_q;

    logic               ag_load, ag_load_down, ag_step, at_end;
    logic [ADDR_W-1:0]  addr;
    elem_t              cur;
    logic [DATA_W-1:0]  exp_rd;
    logic               start_acc, cmp_en, miscmp;

    assign cur       = elem_info(elem_q);
    assign exp_rd    = cur.rd_inv ? ~bg_q : bg_q;
    assign start_acc = start && (state_q == StIdle || state_q == StDone);
    // Read data arriving here belongs to the read issued in the previous cycle
    assign cmp_en    = (state_q == StWrChk) || (state_q == StChkLast);
    assign miscmp    = cmp_en && (mem_readdata != exp_rd);

    bist_addr_gen #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_addr_gen (
        .clk       (clk),
        .reset     (reset),
        .load      (ag_load),
        .load_down (ag_load_down),
        .step      (ag_step),
        .down      (cur.down),
        .addr      (addr),
        .at_end    (at_end)
    );

    always_comb begin
        state_d      = state_q;
        elem_d       = elem_q;
        ag_load      = 1'b0;
        ag_load_down = 1'b0;
        ag_step      = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StWOnly;
                    elem_d  = 3'd0;
                    ag_load = 1'b1;
                end
            end
            StWOnly: begin
                if (at_end) begin
                    state_d = StRd;
                    elem_d  = 3'd1;
                    ag_load = 1'b1;
                end else begin
                    ag_step = 1'b1;
                end
            end
            StRd: state_d = StWrChk;
            StWrChk: begin
                state_d = StRd;
                if (at_end) begin
                    elem_d       = elem_q + 3'd1;
                    ag_load      = 1'b1;
                    ag_load_down = elem_info(elem_q + 3'd1).down;
                    if (elem_q == 3'd4) begin
                        state_d = StRdLast;
                    end
                end else begin
                    ag_step = 1'b1;
                end
            end
            StRdLast: state_d = StChkLast;
            StChkLast: begin
                if (at_end) begin
                    state_d = StDone;
                end else begin
                    ag_step = 1'b1;
                    state_d = StRdLast;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            elem_q      <= 3'd0;
            bg_q        <= '0;
            fail_q      <= 1'b0;
            err_q       <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            fail_exp_q  <= '0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            if (start_acc) begin
                bg_q        <= bg_pattern;
                fail_q      <= 1'b0;
                err_q       <= '0;
                fail_addr_q <= '0;
                fail_data_q <= '0;
                fail_exp_q  <= '0;
            end else if (miscmp) begin
                fail_q <= 1'b1;
                if (err_q != '1) begin
                    err_q <= err_q + ERR_CNT_W'(1);
                end
                if (!fail_q) begin
                    fail_addr_q <= addr;
                    fail_data_q <= mem_readdata;
                    fail_exp_q  <= exp_rd;
                end
            end
        end
    end

    assign busy           = (state_q != StIdle) && (state_q != StDone);
    assign done           = (state_q == StDone);
    assign fail           = fail_q;
    assign fail_addr      = fail_addr_q;
    assign fail_data      = fail_data_q;
    assign fail_expected  = fail_exp_q;
    assign err_count      = err_q;
    assign mem_chipselect = (state_q == StWOnly) || (state_q == StRd) ||
                            (state_q == StWrChk) || (state_q == StRdLast);
    assign mem_write      = (state_q == StWOnly) || (state_q == StWrChk);
    assign mem_writedata  = mem_write ? (cur.wr_inv ? ~bg_q : bg_q) : '0;
    assign mem_address    = busy ? addr : '0;
    assign mem_byteenable = busy ? '1 : '0;
    assign mem_clken      = 1'b1;

endmodule

// File: tb/tb_data_mem_march_bist.sv
// Scoreboard bench for data_mem_march_bist: two DUTs (16- and 2-bit error
// counters) each with a 16-word memory model supporting stuck-at-1 bits.
module tb_data_mem_march_bist;
    import data_mem_bist_pkg::*;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 13;
    localparam int unsigned DATA_W = 32;
    localparam int RunCycles = CYCLES_PER_WORD * DEPTH;

    logic clk = 1'b0;
    logic reset, start;
    logic [DATA_W-1:0] bg_pattern;
    always #5 clk = ~clk;

    logic              busy, done, fail, mem_chipselect, mem_write, mem_clken;
    logic [ADDR_W-1:0] fail_addr, mem_address;
    logic [DATA_W-1:0] fail_data, fail_expected, mem_writedata, mem_readdata;
    logic [15:0]       err_count;
    logic [3:0]        mem_byteenable;

    logic              s_busy, s_done, s_fail, s_mem_chipselect, s_mem_write, s_mem_clken;
    logic [ADDR_W-1:0] s_fail_addr, s_mem_address;
    logic [DATA_W-1:0] s_fail_data, s_fail_expected, s_mem_writedata, s_mem_readdata;
    logic [1:0]        s_err_count;
    logic [3:0]        s_mem_byteenable;

    data_mem_march_bist #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .ERR_CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .bg_pattern(bg_pattern),
        .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr),
        .fail_data(fail_data), .fail_expected(fail_expected), .err_count(err_count),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    data_mem_march_bist #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .ERR_CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .start(start), .bg_pattern(bg_pattern),
        .busy(s_busy), .done(s_done), .fail(s_fail), .fail_addr(s_fail_addr),
        .fail_data(s_fail_data), .fail_expected(s_fail_expected), .err_count(s_err_count),
        .mem_address(s_mem_address), .mem_byteenable(s_mem_byteenable),
        .mem_chipselect(s_mem_chipselect), .mem_write(s_mem_write),
        .mem_writedata(s_mem_writedata), .mem_clken(s_mem_clken),
        .mem_readdata(s_mem_readdata)
    );

    // Memory models: stuck-at-1 masks are OR-ed into both stored and read data
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] sa1 [DEPTH];
    logic [DATA_W-1:0] s_mem [DEPTH];
    logic [DATA_W-1:0] s_sa1 [DEPTH];
    int oob = 0;
    int s_oob = 0;

    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_address >= ADDR_W'(DEPTH)) oob <= oob + 1;
            else if (mem_write) begin
                if (mem_byteenable == 4'hF)
                    mem[mem_address[3:0]] <= mem_writedata | sa1[mem_address[3:0]];
            end else mem_readdata <= mem[mem_address[3:0]] | sa1[mem_address[3:0]];
        end
    end

    always @(posedge clk) begin
        if (s_mem_clken && s_mem_chipselect) begin
            if (s_mem_address >= ADDR_W'(DEPTH)) s_oob <= s_oob + 1;
            else if (s_mem_write) begin
                if (s_mem_byteenable == 4'hF)
                    s_mem[s_mem_address[3:0]] <= s_mem_writedata | s_sa1[s_mem_address[3:0]];
            end else s_mem_readdata <= s_mem[s_mem_address[3:0]] | s_sa1[s_mem_address[3:0]];
        end
    end

    int passed = 0;
    int total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic        fail;
        logic [15:0] err;
        logic [12:0] faddr;
        logic [31:0] fdata;
        logic [31:0] fexp;
        logic [31:0] m1_wd;
        logic [31:0] m2_wd;
        logic        chk_sat;
        logic [1:0]  s_err;
        logic [12:0] s_faddr;
        logic [31:0] s_fdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    // Monitor: counts busy cycles, grabs first M1/M2 write data, scores on done
    int busy_cycles = 0;
    logic busy_prev = 1'b0;
    logic done_prev = 1'b0;
    logic [31:0] m1_wd, m2_wd;

    always @(negedge clk) begin
        if (busy && !busy_prev) busy_cycles = 0;
        if (busy) begin
            if (busy_cycles == DEPTH + 1) m1_wd = mem_writedata;
            if (busy_cycles == 3 * DEPTH + 1) m2_wd = mem_writedata;
            busy_cycles++;
        end
        if (done && !done_prev) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_done: got done=1, want no run pending");
            end else begin
                e = exp_q.pop_front();
                check("busy_cycles", 64'(busy_cycles), 64'(RunCycles));
                check("fail", 64'(fail), 64'(e.fail));
                check("err_count", 64'(err_count), 64'(e.err));
                check("fail_addr", 64'(fail_addr), 64'(e.faddr));
                check("fail_data", 64'(fail_data), 64'(e.fdata));
                check("fail_expected", 64'(fail_expected), 64'(e.fexp));
                check("m1_first_write", 64'(m1_wd), 64'(e.m1_wd));
                check("m2_first_write", 64'(m2_wd), 64'(e.m2_wd));
                check("out_of_range", 64'(oob), 64'(0));
                if (e.chk_sat) begin
                    check("sat_done", 64'({s_done, s_busy, s_fail}), 64'(3'b101));
                    check("sat_err_count", 64'(s_err_count), 64'(e.s_err));
                    check("sat_fail_addr", 64'(s_fail_addr), 64'(e.s_faddr));
                    check("sat_fail_data", 64'(s_fail_data), 64'(e.s_fdata));
                    check("sat_fail_expected", 64'(s_fail_expected), 64'(0));
                    check("sat_out_of_range", 64'(s_oob), 64'(0));
                end
            end
        end
        busy_prev = busy;
        done_prev = done;
    end

    task automatic pulse_start(input logic [31:0] bg);
        @(negedge clk);
        start = 1'b1;
        bg_pattern = bg;
        @(negedge clk);
        start = 1'b0;
        bg_pattern = 32'hDEAD_BEEF;
        check("start_busy", 64'(busy), 64'(1));
        check("start_done_clear", 64'(done), 64'(0));
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            total++;
            $display("FAIL done_timeout: got done=0 after %0d cycles, want done=1", n);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        @(negedge clk);
    endtask

    function automatic exp_t pass_exp(input logic [31:0] bg);
        exp_t x;
        x = '{fail: 1'b0, err: 16'd0, faddr: 13'd0, fdata: 32'd0, fexp: 32'd0,
              m1_wd: ~bg, m2_wd: bg, chk_sat: 1'b0, s_err: 2'd0, s_faddr: 13'd0,
              s_fdata: 32'd0};
        return x;
    endfunction

    exp_t x;

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            sa1[i] = '0;
            s_sa1[i] = '0;
        end
        reset = 1'b1;
        start = 1'b0;
        bg_pattern = '0;
        repeat (3) @(negedge clk);
        check("rst_busy_done_fail", 64'({busy, done, fail}), 64'(0));
        check("rst_err_count", 64'(err_count), 64'(0));
        check("rst_mem_ctrl", 64'({mem_chipselect, mem_write, mem_clken}), 64'(3'b001));
        check("rst_byteenable", 64'(mem_byteenable), 64'(0));
        check("rst_address", 64'(mem_address), 64'(0));
        check("rst_fail_regs", 64'({fail_addr, fail_data, fail_expected} != 0), 64'(0));
        reset = 1'b0;

        // Fault-free, bg = 0
        exp_q.push_back(pass_exp(32'h0000_0000));
        pulse_start(32'h0000_0000);
        wait_done();
        for (int i = 0; i < DEPTH; i++) check($sformatf("final_mem[%0d]", i), 64'(mem[i]), 64'(0));

        // Fault-free, bg = A5; a start during the run must be ignored
        exp_q.push_back(pass_exp(32'hA5A5_A5A5));
        pulse_start(32'hA5A5_A5A5);
        repeat (18) @(negedge clk);
        start = 1'b1;
        bg_pattern = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        check("ignored_start_busy", 64'(busy), 64'(1));
        wait_done();

        // Stuck-at-1 on bit 5 of address 3
        sa1[3] = 32'h0000_0020;
        x = pass_exp(32'h0);
        x.fail = 1'b1;
        x.err = 16'd3;
        x.faddr = 13'd3;
        x.fdata = 32'h0000_0020;
        exp_q.push_back(x);
        pulse_start(32'h0000_0000);
        wait_done();
        sa1[3] = '0;

        // Two stuck bits on the 2-bit counter instance: 6 miscompares saturate at 3
        s_sa1[2] = 32'h0000_0001;
        s_sa1[9] = 32'h8000_0000;
        x = pass_exp(32'h0);
        x.chk_sat = 1'b1;
        x.s_err = 2'd3;
        x.s_faddr = 13'd2;
        x.s_fdata = 32'h0000_0001;
        exp_q.push_back(x);
        pulse_start(32'h0000_0000);
        wait_done();
        s_sa1[2] = '0;
        s_sa1[9] = '0;

        // Reset 40 cycles into a failing run clears everything
        sa1[0] = 32'h0000_0001;
        pulse_start(32'h0000_0000);
        repeat (39) @(negedge clk);
        check("pre_reset_fail", 64'({busy, fail}), 64'(2'b11));
        check("pre_reset_err", 64'(err_count), 64'(1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_reset_busy_done_fail", 64'({busy, done, fail}), 64'(0));
        check("mid_reset_err", 64'(err_count), 64'(0));
        check("mid_reset_cs", 64'(mem_chipselect), 64'(0));
        check("mid_reset_fail_addr", 64'(fail_addr), 64'(0));
        sa1[0] = '0;

        // Full run after the aborted one, then a restart from done
        exp_q.push_back(pass_exp(32'h1234_5678));
        pulse_start(32'h1234_5678);
        wait_done();
        check("done_held", 64'({done, busy}), 64'(2'b10));
        exp_q.push_back(pass_exp(32'hFFFF_0000));
        pulse_start(32'hFFFF_0000);
        wait_done();
        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
